// File: rtl/push_cmd_pkg.sv
// Shared definitions for the push-button command decoder: command codes,
// FSM state encoding, button bit positions and the press-to-command decode.
package push_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_MODE  = 2'd0,
        CMD_UP    = 2'd1,
        CMD_DOWN  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_UP   = 1;
    localparam int unsigned BTN_DOWN = 2;

    // p is the active-high pressed set; UP+DOWN together means CLEAR.
    function automatic cmd_e decode_cmd(input logic [2:0] p);
        if (p[BTN_UP] && p[BTN_DOWN]) return CMD_CLEAR;
        else if (p[BTN_MODE])         return CMD_MODE;
        else if (p[BTN_UP])           return CMD_UP;
        else                          return CMD_DOWN;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO; the head word is read straight from register storage.
// A push on a full FIFO is accepted only when a pop happens on the same edge.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_do_pop) r_rptr <= r_rptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/push_cmd_decoder.sv
// Turns button interrupts into queued time-setting commands, with auto-repeat
// for held UP/DOWN and sticky accounting of commands dropped on a full queue.
module push_cmd_decoder
    import push_cmd_pkg::*;
#(
    parameter int unsigned REPEAT_CYCLES = 50_000_000,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        intr_n,
    input  logic [31:0] intr_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_code,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  drop_cnt
);
    localparam int unsigned CNT_W = $clog2(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REPEAT_CYCLES - 1);

    state_e           r_state, w_state_nxt;
    cmd_e             r_cmd, w_cmd_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       w_pressed;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_unused_bits;

    assign w_pressed     = ~intr_data[2:0];
    assign w_unused_bits = ^intr_data[31:3];
    assign w_pop         = ~w_empty & cmd_ready;
    assign cmd_valid     = ~w_empty;
    assign busy          = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!intr_n && (w_pressed != 3'b000)) begin
                    w_cmd_nxt   = decode_cmd(w_pressed);
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                w_push      = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                // Release takes priority over a repeat due on the same edge.
                if (intr_n) begin
                    w_state_nxt = IDLE;
                end else if (r_cmd == CMD_UP || r_cmd == CMD_DOWN) begin
                    if (r_cnt == CNT_MAX) begin
                        w_push    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_cmd    <= CMD_MODE;
            r_cnt    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_push && w_full && !w_pop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_push   (w_push),
        .i_wdata  (r_cmd),
        .i_pop    (w_pop),
        .o_rdata  (cmd_code),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

endmodule
